// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: mode bit indices, widths, FSM states.
package mac_pkg;

  localparam int unsigned MODE_FP    = 0;
  localparam int unsigned MODE_INT_S = 1;
  localparam int unsigned MODE_INT_M = 2;
  localparam int unsigned MODE_INT_L = 3;

  localparam int unsigned INT_ACC_W = 24;
  localparam int unsigned FP_ACC_W  = 31;
  localparam int unsigned OP_W      = 16;

  localparam logic [4:0] EXP_ZERO = 5'h0c;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic is_onehot4(input logic [3:0] m);
    return (m != 4'b0000) && ((m & (m - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/mac_full.sv
// Combinational MAC core: lane-wise signed int multiply-add, or fp16 product
// aligned into a fixed-exponent accumulator {rsvd, exp[4:0], frac[24:0]}.
module mac_full
  import mac_pkg::*;
(
  input  logic [3:0]           mode,
  input  logic [OP_W-1:0]      value,
  input  logic [OP_W-1:0]      weight,
  input  logic [INT_ACC_W-1:0] ints,
  input  logic [FP_ACC_W-1:0]  fps,
  output logic [INT_ACC_W-1:0] intr,
  output logic [FP_ACC_W-1:0]  fpr
);

  logic [INT_ACC_W-1:0]        w_lane_sum;
  logic signed [7:0]           w_p4;
  logic signed [15:0]          w_p8;
  logic signed [INT_ACC_W-1:0] w_p16;

  always_comb begin
    w_lane_sum = '0;
    w_p4       = '0;
    w_p8       = '0;
    w_p16      = $signed(value) * $signed(weight);
    if (mode[MODE_INT_S]) begin
      for (int unsigned i = 0; i < 4; i++) begin
        w_p4       = $signed(value[4*i +: 4]) * $signed(weight[4*i +: 4]);
        w_lane_sum = w_lane_sum + {{16{w_p4[7]}}, w_p4};
      end
    end else if (mode[MODE_INT_M]) begin
      for (int unsigned i = 0; i < 2; i++) begin
        w_p8       = $signed(value[8*i +: 8]) * $signed(weight[8*i +: 8]);
        w_lane_sum = w_lane_sum + {{8{w_p8[15]}}, w_p8};
      end
    end else if (mode[MODE_INT_L]) begin
      w_lane_sum = w_p16;
    end
  end

  assign intr = ints + w_lane_sum;

  // fp16 zero/subnormal flush to 0; accumulator LSB weighs 2^(exp-EXP_ZERO-12)
  logic [10:0] w_ma, w_mb;
  logic [21:0] w_prod;
  logic [7:0]  w_sh;
  logic [6:0]  w_nsh;
  logic [24:0] w_mag, w_term;

  assign w_ma   = (value[14:10]  == 5'd0) ? 11'd0 : {1'b1, value[9:0]};
  assign w_mb   = (weight[14:10] == 5'd0) ? 11'd0 : {1'b1, weight[9:0]};
  assign w_prod = w_ma * w_mb;
  assign w_sh   = 8'(value[14:10]) + 8'(weight[14:10]) - 8'(fps[29:25])
                + 8'(EXP_ZERO) - 8'd38;
  assign w_nsh  = 7'(8'd0 - w_sh);

  always_comb begin
    if (!w_sh[7]) w_mag = 25'({36'd0, w_prod} << w_sh[6:0]);
    else          w_mag = 25'({36'd0, w_prod} >> w_nsh);
  end

  assign w_term = (value[15] ^ weight[15]) ? (25'd0 - w_mag) : w_mag;
  assign fpr    = mode[MODE_FP] ? {fps[30:25], fps[24:0] + w_term} : fps;

endmodule

// File: rtl/mac_stream_seq.sv
// Job sequencer: streams operand pairs into mac_full, chaining each result
// back as the next bias, and presents the final accumulation on a handshake.
module mac_stream_seq
  import mac_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           cfg_mode,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [INT_ACC_W-1:0] cfg_ints,
  input  logic [FP_ACC_W-1:0]  cfg_fps,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [OP_W-1:0]      op_value,
  input  logic [OP_W-1:0]      op_weight,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [INT_ACC_W-1:0] res_int,
  output logic [FP_ACC_W-1:0]  res_fp,
  output logic                 busy,
  output logic                 err
);

  state_t               r_state;
  logic [3:0]           r_mode;
  logic [LEN_W-1:0]     r_len, r_cnt;
  logic [INT_ACC_W-1:0] r_acc_int;
  logic [FP_ACC_W-1:0]  r_acc_fp;
  logic                 r_op_ready, r_res_valid, r_busy, r_err;
  logic [INT_ACC_W-1:0] w_intr;
  logic [FP_ACC_W-1:0]  w_fpr;
  logic                 w_hs;

  mac_full u_mac (
    .mode   (r_mode),
    .value  (op_value),
    .weight (op_weight),
    .ints   (r_acc_int),
    .fps    (r_acc_fp),
    .intr   (w_intr),
    .fpr    (w_fpr)
  );

  assign w_hs = op_valid && r_op_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mode      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_acc_int   <= '0;
      r_acc_fp    <= '0;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (is_onehot4(cfg_mode) && (cfg_len != '0)) begin
              r_mode     <= cfg_mode;
              r_len      <= cfg_len;
              r_cnt      <= '0;
              r_acc_int  <= cfg_ints;
              r_acc_fp   <= cfg_fps;
              r_op_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_hs) begin
            if (r_mode[MODE_FP]) r_acc_fp  <= w_fpr;
            else                 r_acc_int <= w_intr;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == r_len - 1'b1) begin
              r_op_ready  <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign op_ready  = r_op_ready;
  assign res_valid = r_res_valid;
  assign res_int   = r_acc_int;
  assign res_fp    = r_acc_fp;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
